mmio_st_bridge: RTL and testbench
=================================

// Module: mmio_st_bridge
// PURPOSE
//   Sits between the w450 core's store/load ports and the dual-port mem.
//   Passes ordinary stores and loads through, but claims the top five addresses
//   (2^n-5 .. 2^n-1) as memory-mapped registers: exit/halt, store counter and a
//   cycle counter. Programs finish by storing to 0xFF; benches watch `halted`.
// PARAMETERS
//   n            8   data/address width (matches core and mem)
//   CNT_W        16  cycle counter width (2*n, exposed as HI/LO bytes)
//   HALT_BLOCKS  1   1: stores after halt are dropped; 0: they still reach mem
// PORTS
//   clk          in   1      system clock, all state on rising edge
//   reset        in   1      asynchronous, active-low reset
//   st_en        in   1      core store enable
//   st_addr      in   n      core store address
//   st_data      in   n      core store data
//   ld_addr      in   n      core load address
//   ld_data      out  n      load data to core (mem or MMIO register)
//   mem_wr_en    out  1      mem write enable
//   mem_wr_addr  out  n      mem write address (= st_addr)
//   mem_wr_data  out  n      mem write data (= st_data)
//   mem_ld_addr  out  n      mem read-port-1 address (= ld_addr)
//   mem_ld_data  in   n      mem read-port-1 data
//   halted       out  1      1 once a store to EXIT has committed
//   exit_code    out  n      data of the halting store
// BEHAVIOUR
//   Map (A = 2^n-1): A EXIT(W/R), A-1 CYC_LO(R, W=clear), A-2 CYC_HI(R, W=clear),
//     A-3 STCNT(R, W=clear), A-4 SCRATCH(R/W). mmio_hit = st/ld addr >= A-4.
//   Reset (reset==0, async): state=RUN, halted=0, exit_code=0, cyc=0, stcnt=0,
//     scratch=0. Outputs are combinational from these, so they reflect reset at once.
//   Store path, combinational (zero added latency; mem writes on the same edge):
//     mem_wr_en = st_en & ~mmio_hit & ~(halted & HALT_BLOCKS).
//     mem_wr_addr/data always mirror st_addr/st_data.
//   FSM: RUN -> HALTED on the edge where st_en & st_addr==A in RUN; exit_code<=st_data.
//     HALTED is terminal until reset; a further EXIT store is ignored (exit_code holds).
//   MMIO writes: apply on the clock edge when st_en=1. In HALTED they are ignored
//     iff HALT_BLOCKS=1.
//   Cycle counter (CNT_W bits): +1 every edge in RUN; frozen in HALTED; wraps
//     2^CNT_W-1 -> 0. A store to CYC_LO or CYC_HI loads 0 on that edge (clear wins
//     over increment).
//   STCNT: +1 per edge with mem_wr_en=1; saturates at 2^n-1. A store to STCNT
//     clears it (a clear store never also counts, since it is an MMIO hit).
//   Load path, combinational: mem_ld_addr=ld_addr. ld_data = mem_ld_data unless ld
//     hits MMIO; then the register: EXIT->exit_code, CYC_LO/HI->cyc bytes (live
//     value, no snapshot), STCNT, SCRATCH.
//   Store and load to the same MMIO register in one cycle: the load sees the old value.
//   Reset asserted mid-program: all state clears immediately. The core restarts
//     independently; mem contents are untouched.
// TESTING
//   reset low 2 cycles, release; store 0x80<-0xAA -> mem_wr_en=1, mem[128]=0xAA, STCNT=1
//   store 0xFF<-0x01 -> mem_wr_en=0; next edge halted=1, exit_code=1, cyc frozen
//   after halt, store 0x80<-0x55 (HALT_BLOCKS=1) -> mem[128] stays 0xAA, STCNT unchanged
//   run 10 cycles, load 0xFE -> ld_data=10 (±0 vs edges); store 0xFE -> next load 0x00
//   force cyc 0xFFFF -> next edge cyc=0x0000; 256 stores -> STCNT stays 0xFF
//   store 0xFB<-0x3C then load 0xFB -> 0x3C; assert reset mid-run -> halted=0, all regs 0

Source files
------------

// File: rtl/mmio_st_bridge_if.sv
// Core/memory-side signal bundle for the MMIO store bridge.
// The bridge takes the slave view; the core and memory together take the master view.
interface mmio_st_bridge_if #(
    parameter int n = 8
);
    logic         st_en;
    logic [n-1:0] st_addr;
    logic [n-1:0] st_data;
    logic [n-1:0] ld_addr;
    logic [n-1:0] ld_data;
    logic         mem_wr_en;
    logic [n-1:0] mem_wr_addr;
    logic [n-1:0] mem_wr_data;
    logic [n-1:0] mem_ld_addr;
    logic [n-1:0] mem_ld_data;
    logic         halted;
    logic [n-1:0] exit_code;

    modport slave (
        input  st_en, st_addr, st_data, ld_addr, mem_ld_data,
        output ld_data, mem_wr_en, mem_wr_addr, mem_wr_data, mem_ld_addr,
               halted, exit_code
    );

    modport master (
        output st_en, st_addr, st_data, ld_addr, mem_ld_data,
        input  ld_data, mem_wr_en, mem_wr_addr, mem_wr_data, mem_ld_addr,
               halted, exit_code
    );
endinterface

// File: rtl/mmio_st_bridge.sv
// Store/load bridge between the core and memory that claims the top five
// addresses as registers: exit/halt, cycle counter, store counter and scratch.
module mmio_st_bridge #(
    parameter int n           = 8,
    parameter int CNT_W       = 16,
    parameter bit HALT_BLOCKS = 1'b1
) (
    input logic              clk,
    input logic              reset,
    mmio_st_bridge_if.slave  bus
);
    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_t;

    localparam int WIDE_W = 2 * n;

    localparam logic [n-1:0] ADDR_EXIT    = {n{1'b1}};
    localparam logic [n-1:0] ADDR_CYC_LO  = ADDR_EXIT - n'(1);
    localparam logic [n-1:0] ADDR_CYC_HI  = ADDR_EXIT - n'(2);
    localparam logic [n-1:0] ADDR_STCNT   = ADDR_EXIT - n'(3);
    localparam logic [n-1:0] ADDR_SCRATCH = ADDR_EXIT - n'(4);

    state_t           state_q, state_d;
    logic [n-1:0]     exit_code_q, exit_code_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [n-1:0]     stcnt_q, stcnt_d;
    logic [n-1:0]     scratch_q, scratch_d;

    logic              halted;
    logic              halt_block;
    logic              st_hit;
    logic              mmio_wr;
    logic              mem_wr_en;
    logic [WIDE_W-1:0] cyc_wide;

    assign halted     = (state_q == ST_HALTED);
    assign halt_block = halted & HALT_BLOCKS;
    assign st_hit     = (bus.st_addr >= ADDR_SCRATCH);
    assign mem_wr_en  = bus.st_en & ~st_hit & ~halt_block;
    assign mmio_wr    = bus.st_en & st_hit & ~halt_block;
    assign cyc_wide   = WIDE_W'(cyc_q);

    assign bus.mem_wr_en   = mem_wr_en;
    assign bus.mem_wr_addr = bus.st_addr;
    assign bus.mem_wr_data = bus.st_data;
    assign bus.mem_ld_addr = bus.ld_addr;
    assign bus.halted      = halted;
    assign bus.exit_code   = exit_code_q;

    always_comb begin
        state_d     = state_q;
        exit_code_d = exit_code_q;
        cyc_d       = cyc_q;
        stcnt_d     = stcnt_q;
        scratch_d   = scratch_q;

        case (state_q)
            ST_RUN: begin
                cyc_d = cyc_q + CNT_W'(1);
                if (bus.st_en && bus.st_addr == ADDR_EXIT) begin
                    state_d     = ST_HALTED;
                    exit_code_d = bus.st_data;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (mem_wr_en && stcnt_q != {n{1'b1}}) begin
            stcnt_d = stcnt_q + n'(1);
        end

        // Register clears take priority over the free-running increment.
        if (mmio_wr) begin
            case (bus.st_addr)
                ADDR_CYC_LO,
                ADDR_CYC_HI:  cyc_d     = '0;
                ADDR_STCNT:   stcnt_d   = '0;
                ADDR_SCRATCH: scratch_d = bus.st_data;
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            exit_code_q <= '0;
            cyc_q       <= '0;
            stcnt_q     <= '0;
            scratch_q   <= '0;
        end else begin
            state_q     <= state_d;
            exit_code_q <= exit_code_d;
            cyc_q       <= cyc_d;
            stcnt_q     <= stcnt_d;
            scratch_q   <= scratch_d;
        end
    end

    always_comb begin
        case (bus.ld_addr)
            ADDR_EXIT:    bus.ld_data = exit_code_q;
            ADDR_CYC_LO:  bus.ld_data = cyc_wide[n-1:0];
            ADDR_CYC_HI:  bus.ld_data = cyc_wide[WIDE_W-1:n];
            ADDR_STCNT:   bus.ld_data = stcnt_q;
            ADDR_SCRATCH: bus.ld_data = scratch_q;
            default:      bus.ld_data = bus.mem_ld_data;
        endcase
    end
endmodule

// File: tb/tb_mmio_st_bridge.sv
// Randomised self-checking bench for mmio_st_bridge against a behavioural
// model of the register map, store counting and halt rules.
module tb_mmio_st_bridge;
    localparam bit HB = 1'b1;

    logic clk;
    logic reset;
    logic mem_clear;
    logic [7:0] tb_mem [256];

    int errors;
    int checks;

    logic       cur_en;
    logic [7:0] cur_addr;
    logic [7:0] cur_data;

    logic [7:0] m_mem [256];
    bit         m_halted;
    logic [7:0] m_exit;
    int         m_cyc;
    int         m_stcnt;
    logic [7:0] m_scratch;

    mmio_st_bridge_if #(.n(8)) bus ();

    mmio_st_bridge #(
        .n           (8),
        .CNT_W       (16),
        .HALT_BLOCKS (HB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    assign bus.mem_ld_data = tb_mem[bus.mem_ld_addr];

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= 8'h00;
        end else if (bus.mem_wr_en) begin
            tb_mem[bus.mem_wr_addr] <= bus.mem_wr_data;
        end
    end

    function automatic void model_reset();
        m_halted  = 1'b0;
        m_exit    = 8'h00;
        m_cyc     = 0;
        m_stcnt   = 0;
        m_scratch = 8'h00;
    endfunction

    function automatic bit exp_wr_en();
        return cur_en && (cur_addr < 8'd251) && !(m_halted && HB);
    endfunction

    function automatic logic [7:0] exp_load(input logic [7:0] a);
        case (a)
            8'd255:  return m_exit;
            8'd254:  return 8'(m_cyc % 256);
            8'd253:  return 8'(m_cyc / 256);
            8'd252:  return 8'(m_stcnt);
            8'd251:  return m_scratch;
            default: return m_mem[a];
        endcase
    endfunction

    // One clock edge of the architectural rules, applied to the model.
    function automatic void model_edge();
        bit blocked    = m_halted && HB;
        bit was_halted = m_halted;
        bit cyc_clear  = 1'b0;
        if (cur_en && cur_addr < 8'd251 && !blocked) begin
            m_mem[cur_addr] = cur_data;
            if (m_stcnt < 255) m_stcnt = m_stcnt + 1;
        end
        if (cur_en && cur_addr >= 8'd251 && !blocked) begin
            case (cur_addr)
                8'd255: if (!m_halted) begin
                    m_halted = 1'b1;
                    m_exit   = cur_data;
                end
                8'd254, 8'd253: cyc_clear = 1'b1;
                8'd252: m_stcnt = 0;
                default: m_scratch = cur_data;
            endcase
        end
        if (cyc_clear) m_cyc = 0;
        else if (!was_halted) m_cyc = (m_cyc + 1) % 65536;
    endfunction

    task automatic drive(input logic en, input logic [7:0] a, input logic [7:0] d);
        cur_en      = en;
        cur_addr    = a;
        cur_data    = d;
        bus.st_en   = en;
        bus.st_addr = a;
        bus.st_data = d;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        mem_clear = 1'b1;
        drive(1'b0, 8'h00, 8'h00);
        bus.ld_addr = 8'h00;
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (bus.halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_halted got=%0b exp=0", bus.halted);
        end
        checks++;
        if (bus.exit_code !== 8'h00) begin
            errors++;
            $display("FAIL reset_exit_code got=%0h exp=0", bus.exit_code);
        end
        for (int a = 251; a <= 255; a++) begin
            bus.ld_addr = 8'(a);
            #1;
            checks++;
            if (bus.ld_data !== exp_load(8'(a))) begin
                errors++;
                $display("FAIL reset_reg addr=%0h got=%0h exp=%0h", a, bus.ld_data, exp_load(8'(a)));
            end
        end
        mem_clear = 1'b0;
        reset     = 1'b1;
    endtask

    task automatic test_store_basic();
        drive(1'b1, 8'h80, 8'hAA);
        #1;
        checks++;
        if (bus.mem_wr_en !== exp_wr_en() || bus.mem_wr_addr !== 8'h80 || bus.mem_wr_data !== 8'hAA) begin
            errors++;
            $display("FAIL store_basic_wr got=%0b/%0h/%0h exp=%0b/80/aa",
                     bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data, exp_wr_en());
        end
        tick();
        drive(1'b0, 8'h00, 8'h00);
        checks++;
        if (tb_mem[128] !== m_mem[128]) begin
            errors++;
            $display("FAIL store_basic_mem got=%0h exp=%0h", tb_mem[128], m_mem[128]);
        end
        bus.ld_addr = 8'hFC;
        #1;
        checks++;
        if (bus.ld_data !== exp_load(8'hFC)) begin
            errors++;
            $display("FAIL store_basic_stcnt got=%0h exp=%0h", bus.ld_data, exp_load(8'hFC));
        end
    endtask

    task automatic test_random_run();
        logic [7:0] a, la;
        for (int i = 0; i < 200; i++) begin
            a  = 8'($urandom_range(0, 254));
            la = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) a  = 8'(251 + $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) la = 8'(251 + $urandom_range(0, 4));
            drive(1'($urandom_range(0, 1)), a, 8'($urandom));
            bus.ld_addr = la;
            #1;
            checks++;
            if (bus.mem_wr_en !== exp_wr_en()) begin
                errors++;
                $display("FAIL random_wr_en cyc=%0d addr=%0h got=%0b exp=%0b", i, a, bus.mem_wr_en, exp_wr_en());
            end
            checks++;
            if (bus.ld_data !== exp_load(la)) begin
                errors++;
                $display("FAIL random_ld cyc=%0d addr=%0h got=%0h exp=%0h", i, la, bus.ld_data, exp_load(la));
            end
            tick();
        end
        drive(1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_cycle_counter();
        drive(1'b1, 8'hFE, 8'h5A);
        tick();
        drive(1'b0, 8'h00, 8'h00);
        repeat (10) tick();
        bus.ld_addr = 8'hFE;
        #1;
        checks++;
        if (bus.ld_data !== 8'd10 || exp_load(8'hFE) !== 8'd10) begin
            errors++;
            $display("FAIL cyc_run10 got=%0h exp=0a", bus.ld_data);
        end
        drive(1'b1, 8'hFE, 8'h00);
        tick();
        drive(1'b0, 8'h00, 8'h00);
        checks++;
        if (bus.ld_data !== exp_load(8'hFE)) begin
            errors++;
            $display("FAIL cyc_clear_lo got=%0h exp=%0h", bus.ld_data, exp_load(8'hFE));
        end
    endtask

    task automatic test_cycle_wrap();
        drive(1'b1, 8'hFD, 8'h00);
        tick();
        drive(1'b0, 8'h00, 8'h00);
        repeat (65535) tick();
        for (int a = 253; a <= 254; a++) begin
            bus.ld_addr = 8'(a);
            #1;
            checks++;
            if (bus.ld_data !== exp_load(8'(a))) begin
                errors++;
                $display("FAIL cyc_max addr=%0h got=%0h exp=%0h", a, bus.ld_data, exp_load(8'(a)));
            end
        end
        tick();
        for (int a = 253; a <= 254; a++) begin
            bus.ld_addr = 8'(a);
            #1;
            checks++;
            if (bus.ld_data !== exp_load(8'(a))) begin
                errors++;
                $display("FAIL cyc_wrap addr=%0h got=%0h exp=%0h", a, bus.ld_data, exp_load(8'(a)));
            end
        end
    endtask

    task automatic test_stcnt_saturate();
        drive(1'b1, 8'hFC, 8'h00);
        tick();
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 8'($urandom_range(0, 250)), 8'($urandom));
            tick();
            if (i == 254 || i == 255) begin
                bus.ld_addr = 8'hFC;
                #1;
                checks++;
                if (bus.ld_data !== exp_load(8'hFC) || m_stcnt != 255) begin
                    errors++;
                    $display("FAIL stcnt_sat n=%0d got=%0h exp=ff", i + 1, bus.ld_data);
                end
            end
        end
        drive(1'b1, 8'hFC, 8'h99);
        tick();
        drive(1'b0, 8'h00, 8'h00);
        bus.ld_addr = 8'hFC;
        #1;
        checks++;
        if (bus.ld_data !== exp_load(8'hFC)) begin
            errors++;
            $display("FAIL stcnt_clear got=%0h exp=%0h", bus.ld_data, exp_load(8'hFC));
        end
    endtask

    task automatic test_scratch();
        drive(1'b1, 8'hFB, 8'h3C);
        bus.ld_addr = 8'hFB;
        #1;
        checks++;
        if (bus.ld_data !== exp_load(8'hFB)) begin
            errors++;
            $display("FAIL scratch_same_cycle got=%0h exp=%0h", bus.ld_data, exp_load(8'hFB));
        end
        tick();
        drive(1'b0, 8'h00, 8'h00);
        checks++;
        if (bus.ld_data !== 8'h3C) begin
            errors++;
            $display("FAIL scratch_rd got=%0h exp=3c", bus.ld_data);
        end
    endtask

    task automatic test_halt();
        logic [7:0] frozen_lo;
        drive(1'b1, 8'hFF, 8'h01);
        bus.ld_addr = 8'hFF;
        #1;
        checks++;
        if (bus.mem_wr_en !== 1'b0 || bus.halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_pre got=%0b/%0b exp=0/0", bus.mem_wr_en, bus.halted);
        end
        tick();
        drive(1'b0, 8'h00, 8'h00);
        checks++;
        if (bus.halted !== 1'b1 || bus.exit_code !== 8'h01 || bus.ld_data !== exp_load(8'hFF)) begin
            errors++;
            $display("FAIL halt_post got=%0b/%0h/%0h exp=1/01/01", bus.halted, bus.exit_code, bus.ld_data);
        end
        bus.ld_addr = 8'hFE;
        #1;
        frozen_lo = exp_load(8'hFE);
        repeat (5) tick();
        checks++;
        if (bus.ld_data !== frozen_lo || exp_load(8'hFE) !== frozen_lo) begin
            errors++;
            $display("FAIL halt_cyc_frozen got=%0h exp=%0h", bus.ld_data, frozen_lo);
        end
    endtask

    task automatic test_halt_blocks();
        drive(1'b1, 8'h80, 8'h55);
        #1;
        checks++;
        if (bus.mem_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL halt_block_wr_en got=%0b exp=0", bus.mem_wr_en);
        end
        tick();
        checks++;
        if (tb_mem[128] !== m_mem[128]) begin
            errors++;
            $display("FAIL halt_block_mem got=%0h exp=%0h", tb_mem[128], m_mem[128]);
        end
        drive(1'b1, 8'hFF, 8'h77);
        tick();
        drive(1'b1, 8'hFB, 8'hC3);
        tick();
        drive(1'b0, 8'h00, 8'h00);
        checks++;
        if (bus.exit_code !== 8'h01) begin
            errors++;
            $display("FAIL halt_exit_hold got=%0h exp=01", bus.exit_code);
        end
        for (int a = 251; a <= 252; a++) begin
            bus.ld_addr = 8'(a);
            #1;
            checks++;
            if (bus.ld_data !== exp_load(8'(a))) begin
                errors++;
                $display("FAIL halt_block_reg addr=%0h got=%0h exp=%0h", a, bus.ld_data, exp_load(8'(a)));
            end
        end
    endtask

    task automatic test_reset_midrun();
        logic [7:0] keep;
        keep = m_mem[128];
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.halted !== 1'b0 || bus.exit_code !== 8'h00) begin
            errors++;
            $display("FAIL midrun_reset got=%0b/%0h exp=0/00", bus.halted, bus.exit_code);
        end
        for (int a = 251; a <= 254; a++) begin
            bus.ld_addr = 8'(a);
            #1;
            checks++;
            if (bus.ld_data !== 8'h00) begin
                errors++;
                $display("FAIL midrun_reg addr=%0h got=%0h exp=00", a, bus.ld_data);
            end
        end
        bus.ld_addr = 8'h80;
        #1;
        checks++;
        if (bus.ld_data !== keep) begin
            errors++;
            $display("FAIL midrun_mem got=%0h exp=%0h", bus.ld_data, keep);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) tick();
        bus.ld_addr = 8'hFE;
        #1;
        checks++;
        if (bus.ld_data !== exp_load(8'hFE)) begin
            errors++;
            $display("FAIL midrun_restart_cyc got=%0h exp=%0h", bus.ld_data, exp_load(8'hFE));
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_store_basic();
        test_random_run();
        test_cycle_counter();
        test_cycle_wrap();
        test_stcnt_saturate();
        test_scratch();
        test_halt();
        test_halt_blocks();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
